fp_dot_sequencer: RTL

Initiator-side sequencer for the extended floating-point ALU. It computes an IEEE-754 single-precision dot product of two vectors held in synchronous-read memories. For each element it issues one MULF and one ADDF to the ALU and folds each result back into an accumulator. It sits between the recognition-layer controller, which supplies start/base/len, and the extended ALU operand and result ports, and serves as the multiply-accumulate engine for neuron evaluation.

---
 rtl/fp_dot_sequencer.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/fp_dot_sequencer.sv
// ---------------------------------------------------------------------------
// fp_dot_sequencer
//
// Multiply-accumulate engine for neuron evaluation. It computes an FP32 dot
// product of two vectors held in synchronous-read memories by driving the
// extended floating-point ALU one operation at a time. Each element takes
// four cycles: FETCH (memory read), MUL (issue MULF), ADD (issue ADDF of
// accumulator + product) and ACC (fold the sum back into the accumulator).
// Elements are accumulated strictly from index 0 upward, so the rounding
// sequence is deterministic and entirely the ALU's.
//
// Optional build macro:
//   FP_DOT_RELU_EN - when defined, the final sum passes through ReLU before
//                    it is loaded into result (any value with the sign bit
//                    set, including -0.0, becomes +0.0). Latency unchanged.
//
// Handshake: start is a single-cycle request sampled only in IDLE together
// with a_base/b_base/len; a start seen in any other state is dropped, never
// queued. done is a one-cycle pulse that coincides with result becoming
// valid; result then holds until the next done or reset.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   start                 job request (IDLE only)
//   a_base, b_base, len   vector base addresses and element count
//   busy                  high from FETCH of element 0 through the last ACC
//   done                  one-cycle result-valid pulse
//   result                final FP32 dot product
//   rd_en                 memory read strobe (FETCH only)
//   rd_addr_a, rd_addr_b  base + idx, wrapping modulo 2^ADDR_W
//   rd_data_a, rd_data_b  memory data, valid the cycle after rd_en
//   alu_src1, alu_src0    ALU operands (zero outside MUL/ADD)
//   alu_func              ALU function: MULF=100, ADDF=010, idle 000
//   alu_dst               registered ALU result (one cycle after issue)
//   dbg_state             current FSM state encoding
// ---------------------------------------------------------------------------
module fp_dot_sequencer #(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] a_base,
  input  logic [ADDR_W-1:0] b_base,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic [31:0]       result,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr_a,
  output logic [ADDR_W-1:0] rd_addr_b,
  input  logic [31:0]       rd_data_a,
  input  logic [31:0]       rd_data_b,
  output logic [31:0]       alu_src1,
  output logic [31:0]       alu_src0,
  output logic [2:0]        alu_func,
  input  logic [31:0]       alu_dst,
  output logic [2:0]        dbg_state
);

  localparam logic [2:0] FUNC_IDLE = 3'b000;
  localparam logic [2:0] FUNC_MULF = 3'b100;
  localparam logic [2:0] FUNC_ADDF = 3'b010;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    MUL   = 3'd2,
    ADD   = 3'd3,
    ACC   = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   a_base_q, b_base_q;
  logic [LEN_W-1:0]    len_q;
  logic [LEN_W-1:0]    idx_q;
  logic [31:0]         acc_q;
  logic [31:0]         result_q;
  logic                done_q;
  logic                last_elem;
  logic [31:0]         final_val;

  // len_q is never zero while the element loop runs (len=0 bypasses it),
  // so len_q-1 cannot underflow here.
  assign last_elem = (idx_q == (len_q - LEN_W'(1)));

`ifdef FP_DOT_RELU_EN
  assign final_val = alu_dst[31] ? 32'h0000_0000 : alu_dst;
`else
  assign final_val = alu_dst;
`endif

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (len == '0) ? DONE : FETCH;
      FETCH:   state_d = MUL;
      MUL:     state_d = ADD;
      ADD:     state_d = ACC;
      ACC:     state_d = last_elem ? DONE : FETCH;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_base_q <= '0;
      b_base_q <= '0;
      len_q    <= '0;
      idx_q    <= '0;
      acc_q    <= 32'h0000_0000;
      result_q <= 32'h0000_0000;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_d == DONE);
      case (state_q)
        IDLE: begin
          if (start) begin
            if (len == '0) begin
              // Empty vector: no memory or ALU traffic, result is +0.0.
              result_q <= 32'h0000_0000;
            end else begin
              a_base_q <= a_base;
              b_base_q <= b_base;
              len_q    <= len;
              idx_q    <= '0;
              acc_q    <= 32'h0000_0000;
            end
          end
        end
        ACC: begin
          acc_q <= alu_dst;
          idx_q <= idx_q + LEN_W'(1);
          // result is loaded on the same edge that raises done.
          if (last_elem) result_q <= final_val;
        end
        default: ;
      endcase
    end
  end

  // Output decode (all derived from registered state)
  always_comb begin
    alu_src1 = 32'h0000_0000;
    alu_src0 = 32'h0000_0000;
    alu_func = FUNC_IDLE;
    case (state_q)
      MUL: begin
        alu_src1 = rd_data_a;
        alu_src0 = rd_data_b;
        alu_func = FUNC_MULF;
      end
      ADD: begin
        // alu_dst holds the product issued in MUL.
        alu_src1 = acc_q;
        alu_src0 = alu_dst;
        alu_func = FUNC_ADDF;
      end
      default: ;
    endcase
  end

  assign busy      = (state_q == FETCH) || (state_q == MUL) ||
                     (state_q == ADD)   || (state_q == ACC);
  assign rd_en     = (state_q == FETCH);
  // Address arithmetic wraps silently at 2^ADDR_W.
  assign rd_addr_a = a_base_q + ADDR_W'(idx_q);
  assign rd_addr_b = b_base_q + ADDR_W'(idx_q);
  assign done      = done_q;
  assign result    = result_q;
  assign dbg_state = state_q;

endmodule
